// File: rtl/regfile_write_buffer_pkg.sv
// rtl/regfile_write_buffer_pkg.sv - shared register-file constants
package regfile_write_buffer_pkg;

    localparam int REG_W    = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;

    localparam logic [REG_W-1:0] ZERO_REG = 4'd0;

endpackage

// File: rtl/regfile_write_buffer_wb_fifo_ctrl.sv
// rtl/regfile_write_buffer_wb_fifo_ctrl.sv - head/tail/count control for the write buffer
module wb_fifo_ctrl
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pushReq,
    input  logic             hold,
    output logic             inReady,
    output logic             pushEn,
    output logic             popEn,
    output logic [PTR_W-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic [PTR_W-1:0] tail,
    output logic             empty,
    output logic             full
);

    // Handshake and drain qualification; reset blocks both directions.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(DEPTH));
        inReady = ~full & ~rst;
        pushEn  = pushReq & inReady;
        popEn   = ~empty & ~hold & ~rst;
    end

    // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pushEn) tail <= tail + PTR_W'(1);
            if (popEn)  head <= head + PTR_W'(1);
            case ({pushEn, popEn})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// rtl/regfile_write_buffer.sv - queued register-file write port with forwarding lookups
module regfile_write_buffer
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int REG_W  = regfile_write_buffer_pkg::REG_W,
    parameter int DATA_W = regfile_write_buffer_pkg::DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    output logic [REG_W-1:0]  DstReg,
    output logic [DATA_W-1:0] DstData,
    output logic              WriteReg,
    input  logic [REG_W-1:0]  q_reg1,
    input  logic [REG_W-1:0]  q_reg2,
    output logic              q_hit1,
    output logic              q_hit2,
    output logic [DATA_W-1:0] q_data1,
    output logic [DATA_W-1:0] q_data2,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam logic [REG_W-1:0] zeroReg = REG_W'(ZERO_REG);

    logic [REG_W-1:0]  entryReg  [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];

    logic             pushReq;
    logic             pushEn;
    logic             popEn;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Writes to register 0 complete the handshake but never enter the queue.
    assign pushReq = in_valid & (in_reg != zeroReg);

    wb_fifo_ctrl #(
        .DEPTH(DEPTH)
    ) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .pushReq(pushReq),
        .hold   (hold),
        .inReady(in_ready),
        .pushEn (pushEn),
        .popEn  (popEn),
        .head   (head),
        .count  (count),
        .tail   (tail),
        .empty  (empty),
        .full   (full)
    );

    // Entry storage; validity comes from head/count, so no per-entry reset is needed.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            entryReg[tail]  <= in_reg;
            entryData[tail] <= in_data;
        end
    end

    // Head entry drives the register-file write port.
    always_comb begin
        WriteReg = popEn;
        DstReg   = '0;
        DstData  = '0;
        if (!empty) begin
            DstReg  = entryReg[head];
            DstData = entryData[head];
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PTR_W-1:0] lookIdx;
        q_hit1  = 1'b0;
        q_hit2  = 1'b0;
        q_data1 = '0;
        q_data2 = '0;
        lookIdx = head;
        for (int k = 0; k < DEPTH; k++) begin
            lookIdx = head + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if ((entryReg[lookIdx] == q_reg1) && (q_reg1 != zeroReg)) begin
                    q_hit1  = 1'b1;
                    q_data1 = entryData[lookIdx];
                end
                if ((entryReg[lookIdx] == q_reg2) && (q_reg2 != zeroReg)) begin
                    q_hit2  = 1'b1;
                    q_data2 = entryData[lookIdx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb/tb_regfile_write_buffer.sv - self-checking bench for regfile_write_buffer
module tb_regfile_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_reg;
    logic [15:0] in_data;
    logic        hold;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic        WriteReg;
    logic [3:0]  q_reg1;
    logic [3:0]  q_reg2;
    logic        q_hit1;
    logic        q_hit2;
    logic [15:0] q_data1;
    logic [15:0] q_data2;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t mq[$];

    regfile_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_reg  (in_reg),
        .in_data (in_data),
        .hold    (hold),
        .DstReg  (DstReg),
        .DstData (DstData),
        .WriteReg(WriteReg),
        .q_reg1  (q_reg1),
        .q_reg2  (q_reg2),
        .q_hit1  (q_hit1),
        .q_hit2  (q_hit2),
        .q_data1 (q_data1),
        .q_data2 (q_data2),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] model_lookup(input logic [3:0] q);
        if (q == 4'd0) return 17'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].r == q) return {1'b1, mq[i].d};
        return 17'd0;
    endfunction

    task automatic test_reset();
        rst = 1; hold = 0; in_valid = 1; in_reg = 4'd5; in_data = 16'h5555;
        q_reg1 = 4'd5; q_reg2 = 4'd0;
        step();
        nCompared++;
        if ({in_ready, WriteReg} !== 2'b00) begin
            nMismatched++;
            $display("FAIL reset_hs: in_ready,WriteReg=%b required 00", {in_ready, WriteReg});
        end
        rst = 0; in_valid = 0;
        #1;
        nCompared++;
        if ({count, empty, full, WriteReg, DstReg, DstData, q_hit1, q_hit2, q_data1, q_data2}
            !== {3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0}) begin
            nMismatched++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b wr=%b dst=%h:%h hit=%b%b required 0 1 0 0 0:0000 00",
                     count, empty, full, WriteReg, DstReg, DstData, q_hit1, q_hit2);
        end
    endtask

    task automatic test_single();
        hold = 0; in_valid = 1; in_reg = 4'd5; in_data = 16'h1234; q_reg1 = 4'd5;
        #1;
        nCompared++;
        if (q_hit1 !== 1'b0) begin
            nMismatched++;
            $display("FAIL single_prestore_hit: q_hit1=%b required 0", q_hit1);
        end
        step();
        in_valid = 0;
        #1;
        nCompared++;
        if ({WriteReg, DstReg, DstData, q_hit1, q_data1, count} !== {1'b1, 4'd5, 16'h1234, 1'b1, 16'h1234, 3'd1}) begin
            nMismatched++;
            $display("FAIL single_out: wr=%b dst=%h:%h hit=%b data=%h count=%0d required 1 5:1234 1 1234 1",
                     WriteReg, DstReg, DstData, q_hit1, q_data1, count);
        end
        step();
        nCompared++;
        if ({empty, WriteReg, q_hit1} !== 3'b100) begin
            nMismatched++;
            $display("FAIL single_drained: empty=%b wr=%b hit=%b required 1 0 0", empty, WriteReg, q_hit1);
        end
    endtask

    task automatic test_hold_full();
        logic [3:0]  regs [4];
        logic [15:0] datas [4];
        regs  = '{4'd3, 4'd3, 4'd7, 4'd9};
        datas = '{16'hAAAA, 16'hBBBB, 16'h0007, 16'h0009};
        hold = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_reg = regs[i]; in_data = datas[i];
            step();
        end
        in_valid = 1; in_reg = 4'd11; in_data = 16'hDEAD; q_reg1 = 4'd3;
        #1;
        nCompared++;
        if ({full, in_ready, count, q_hit1, q_data1, WriteReg} !== {1'b1, 1'b0, 3'd4, 1'b1, 16'hBBBB, 1'b0}) begin
            nMismatched++;
            $display("FAIL hold_full: full=%b rdy=%b count=%0d hit=%b data=%h wr=%b required 1 0 4 1 BBBB 0",
                     full, in_ready, count, q_hit1, q_data1, WriteReg);
        end
        step();
        in_valid = 0;
        q_reg2 = 4'd11;
        #1;
        nCompared++;
        if ({count, q_hit2} !== {3'd4, 1'b0}) begin
            nMismatched++;
            $display("FAIL hold_fifth_rejected: count=%0d hit2=%b required 4 0", count, q_hit2);
        end
        hold = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            nCompared++;
            if ({WriteReg, DstReg, DstData} !== {1'b1, regs[i], datas[i]}) begin
                nMismatched++;
                $display("FAIL hold_drain_%0d: wr=%b dst=%h:%h required 1 %h:%h",
                         i, WriteReg, DstReg, DstData, regs[i], datas[i]);
            end
            step();
        end
        nCompared++;
        if ({empty, WriteReg} !== 2'b10) begin
            nMismatched++;
            $display("FAIL hold_drain_end: empty=%b wr=%b required 1 0", empty, WriteReg);
        end
        q_reg2 = 4'd0;
    endtask

    task automatic test_reg0();
        hold = 0; in_valid = 1; in_reg = 4'd0; in_data = 16'hFFFF; q_reg2 = 4'd0;
        #1;
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL reg0_ready: in_ready=%b required 1", in_ready);
        end
        step();
        in_valid = 0;
        #1;
        nCompared++;
        if ({count, WriteReg, q_hit2, q_data2} !== {3'd0, 1'b0, 1'b0, 16'd0}) begin
            nMismatched++;
            $display("FAIL reg0_discard: count=%0d wr=%b hit2=%b data2=%h required 0 0 0 0000",
                     count, WriteReg, q_hit2, q_data2);
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        mq.delete();
        hold = 1;
        for (int i = 0; i < 2; i++) begin
            e.r = 4'(i + 1); e.d = 16'($urandom);
            in_valid = 1; in_reg = e.r; in_data = e.d;
            mq.push_back(e);
            step();
        end
        hold = 0;
        for (int i = 0; i < 10; i++) begin
            e.r = 4'((i % 15) + 1); e.d = 16'($urandom);
            in_valid = 1; in_reg = e.r; in_data = e.d;
            #1;
            nCompared++;
            if ({WriteReg, DstReg, DstData} !== {1'b1, mq[0].r, mq[0].d}) begin
                nMismatched++;
                $display("FAIL b2b_write_%0d: wr=%b dst=%h:%h required 1 %h:%h",
                         i, WriteReg, DstReg, DstData, mq[0].r, mq[0].d);
            end
            void'(mq.pop_front());
            mq.push_back(e);
            step();
            nCompared++;
            if (count !== 3'd2) begin
                nMismatched++;
                $display("FAIL b2b_count_%0d: count=%0d required 2", i, count);
            end
        end
        in_valid = 0;
        step();
        step();
        mq.delete();
    endtask

    task automatic test_reset_mid();
        hold = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_reg = 4'd6; in_data = 16'(i);
            step();
        end
        in_valid = 0; hold = 0; rst = 1; q_reg1 = 4'd6; q_reg2 = 4'd6;
        #1;
        nCompared++;
        if ({WriteReg, in_ready} !== 2'b00) begin
            nMismatched++;
            $display("FAIL rstmid_during: wr=%b rdy=%b required 0 0", WriteReg, in_ready);
        end
        step();
        rst = 0;
        #1;
        nCompared++;
        if ({count, empty, WriteReg, DstReg, DstData, q_hit1, q_hit2}
            !== {3'd0, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0}) begin
            nMismatched++;
            $display("FAIL rstmid_after: count=%0d empty=%b wr=%b dst=%h:%h hit=%b%b required 0 1 0 0:0000 00",
                     count, empty, WriteReg, DstReg, DstData, q_hit1, q_hit2);
        end
        step();
        nCompared++;
        if (WriteReg !== 1'b0) begin
            nMismatched++;
            $display("FAIL rstmid_nowrite: wr=%b required 0", WriteReg);
        end
    endtask

    task automatic test_random();
        ent_t e;
        logic [16:0] exp1, exp2;
        logic        expWr;
        logic [3:0]  expReg;
        logic [15:0] expData;
        int pushed = 0;
        int written = 0;
        mq.delete();
        for (int cyc = 0; cyc < 500; cyc++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_reg   = 4'($urandom_range(0, 15));
            in_data  = 16'($urandom);
            hold     = (cyc < 480) ? ($urandom_range(0, 9) < 4) : 1'b0;
            if (cyc >= 480) in_valid = 0;
            q_reg1   = 4'($urandom_range(0, 15));
            q_reg2   = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].r : 4'd0;
            #1;
            expWr   = (mq.size() > 0) && !hold;
            expReg  = (mq.size() > 0) ? mq[0].r : 4'd0;
            expData = (mq.size() > 0) ? mq[0].d : 16'd0;
            exp1 = model_lookup(q_reg1);
            exp2 = model_lookup(q_reg2);
            nCompared++;
            if ({in_ready, WriteReg, DstReg, DstData, count}
                !== {(mq.size() < DEPTH), expWr, expReg, expData, 3'(mq.size())}) begin
                nMismatched++;
                $display("FAIL rand_drain_%0d: rdy=%b wr=%b dst=%h:%h count=%0d required %b %b %h:%h %0d",
                         cyc, in_ready, WriteReg, DstReg, DstData, count,
                         (mq.size() < DEPTH), expWr, expReg, expData, mq.size());
            end
            nCompared++;
            if ({q_hit1, q_data1, q_hit2, q_data2} !== {exp1, exp2}) begin
                nMismatched++;
                $display("FAIL rand_lookup_%0d: p1=%b:%h p2=%b:%h required %b:%h %b:%h",
                         cyc, q_hit1, q_data1, q_hit2, q_data2, exp1[16], exp1[15:0], exp2[16], exp2[15:0]);
            end
            if (WriteReg) written++;
            if (expWr) void'(mq.pop_front());
            if (in_valid && (mq.size() + (expWr ? 1 : 0) < DEPTH) && in_reg != 4'd0) begin
                e.r = in_reg; e.d = in_data;
                mq.push_back(e);
                pushed++;
            end
            step();
        end
        nCompared++;
        if (written !== pushed || mq.size() != 0) begin
            nMismatched++;
            $display("FAIL rand_totals: written=%0d left=%0d required %0d 0", written, mq.size(), pushed);
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; in_reg = 0; in_data = 0; hold = 0; q_reg1 = 0; q_reg2 = 0;
        test_reset();
        test_single();
        test_hold_full();
        test_reg0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
